stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//   N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshake.
//   Parametrised successor to the combinational 2:1 MUX: CHANNELS inputs, one output
//   register stage, selectable fixed-select or round-robin arbitration. Merges
//   producer streams onto a single datapath consumer in the simpleArchitecture core.
// PARAMETERS
//   WIDTH     4  data width per channel, in bits
//   CHANNELS  4  number of input channels (>=2)
//   SEL_W     2  select/grant width; must satisfy 2**SEL_W >= CHANNELS
// PORTS
//   clk        in   1               rising-edge clock
//   rst_n      in   1               async active-low reset
//   in_data    in   CHANNELS*WIDTH  channel i data at [i*WIDTH +: WIDTH]
//   in_valid   in   CHANNELS        channel i has data
//   in_ready   out  CHANNELS        channel i word accepted this cycle (if valid)
//   mode       in   1               0 = fixed select (sel), 1 = round-robin
//   sel        in   SEL_W           channel index used when mode = 0
//   out_data   out  WIDTH           registered output data
//   out_valid  out  1               out_data holds a word
//   out_ready  in   1               consumer accepts out_data
//   grant      out  SEL_W           source channel of the current out_data
// BEHAVIOUR
//   Reset (async, rst_n=0): out_valid=0, out_data=0, grant=0, rr_ptr=CHANNELS-1;
//     in_ready all 0 while in reset. Release is synchronous to clk.
//   load_en = !out_valid | out_ready (register empty or being drained this cycle).
//   Fixed mode: chosen = sel; in_ready[sel] = load_en; all other in_ready = 0.
//     sel >= CHANNELS -> no channel chosen, in_ready all 0, no transfer.
//   RR mode: scan channels rr_ptr+1, rr_ptr+2, ... mod CHANNELS; first with in_valid=1
//     is chosen; in_ready[chosen] = load_en; others 0. No valid -> in_ready all 0.
//     in_ready depends combinationally on in_valid in this mode only.
//   Transfer on channel c: in_valid[c] & in_ready[c]. On the next edge:
//     out_data <= in_data[c], grant <= c, out_valid <= 1; in RR mode rr_ptr <= c.
//   No transfer but out_valid & out_ready: out_valid <= 0; out_data and grant hold.
//   Hold: out_valid & !out_ready -> out_data, grant, out_valid stable regardless of
//     sel/mode/in_* changes.
//   Latency: 1 cycle input-to-output; throughput 1 word/cycle under continuous
//     out_ready (simultaneous drain and load in the same cycle).
//   rr_ptr updates only on RR-mode transfers; fixed-mode transfers leave it unchanged.
//     Mode switch takes effect on the same cycle's selection (mode is not registered).
//   Wrap-around: pointer at CHANNELS-1 -> scan restarts at channel 0.
//   Reset mid-operation: any held word is dropped (out_valid=0), rr_ptr restored.
// TESTING
//   1 Reset: rst_n=0 with in_valid=4'hF -> out_valid=0, out_data=0, grant=0, in_ready=0.
//   2 Fixed: mode=0, sel=2, lane2=4'b1010 valid, out_ready=1 -> next cycle out_data=1010,
//     grant=2; sel=3 lane3=4'b0101 -> out_data=0101, grant=3; sel=5 -> in_ready=0.
//   3 Backpressure: out_valid=1, out_ready=0 for 3 cycles while sel/in_data change ->
//     out_data, grant constant, in_ready=0; out_ready=1 -> new word the following cycle.
//   4 RR fairness: mode=1, in_valid=4'hF, out_ready=1 -> grant 0,1,2,3,0,1 on
//     consecutive cycles; in_valid=4'b1010 -> grant alternates 1,3,1.
//   5 RR wrap/skip: rr_ptr=3, in_valid=4'b0100 -> grant=2; then in_valid=4'b0001 -> 0.
//   6 Reset mid-stream: assert rst_n=0 between clk edges while out_valid=1 ->
//     out_valid drops immediately; after release first RR grant is channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream mux with valid/ready handshake.
// Supports fixed-select and round-robin arbitration onto one output register.
module stream_mux_rr #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          grant
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] chosen;
  logic             hit;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] pick;
  logic [IW-1:0]    idx;

  assign load_en = !out_valid | out_ready;

  // Pick a channel: fixed select, or first valid lane after rr_ptr.
  always_comb begin
    chosen = '0;
    hit    = 1'b0;
    idx    = '0;
    if (!mode) begin
      if (int'(sel) < CHANNELS) begin
        chosen = sel;
        hit    = 1'b1;
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        idx = IW'((int'(rr_ptr) + k) % CHANNELS);
        if (!hit && in_valid[idx]) begin
          hit    = 1'b1;
          chosen = SEL_W'(idx);
        end
      end
    end
  end

  // Ready goes only to the chosen lane, and only when the register can load.
  always_comb begin
    in_ready = '0;
    pick     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chosen == SEL_W'(i)) begin
        in_ready[i] = hit & load_en & rst_n;
        pick        = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= pick;
      grant     <= chosen;
      if (mode) rr_ptr <= chosen;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of fixed/RR muxing, backpressure, reset.
// Instance uses SEL_W=3 so out-of-range select values are reachable.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  grant;

  int checks = 0;
  int failures = 0;

  stream_mux_rr #(.WIDTH(4), .CHANNELS(4), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; in_data = 16'hFFFF;
    mode = 1'b0; sel = 3'd0; out_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 4'h0) begin failures++;
      $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (grant !== 3'd0) begin failures++;
      $display("FAIL reset_grant got=%0d exp=0", grant); end
    checks++; if (in_ready !== 4'h0) begin failures++;
      $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    in_valid = 4'h0;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 3'd2; in_data = 16'h0A00; in_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++;
      $display("FAIL fix_ready2 got=%b exp=0100", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 4'hA || grant !== 3'd2) begin
      failures++;
      $display("FAIL fix_lane2 got v=%b d=%h g=%0d exp v=1 d=a g=2",
               out_valid, out_data, grant); end
    sel = 3'd3; in_data = 16'h5000; in_valid = 4'b1000;
    tick();
    checks++; if (out_data !== 4'h5 || grant !== 3'd3) begin failures++;
      $display("FAIL fix_lane3 got d=%h g=%0d exp d=5 g=3", out_data, grant); end
    sel = 3'd5; in_valid = 4'hF; in_data = 16'h1234;
    #1;
    checks++; if (in_ready !== 4'h0) begin failures++;
      $display("FAIL fix_sel5_ready got=%b exp=0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 4'h5 || grant !== 3'd3) begin
      failures++;
      $display("FAIL fix_sel5_drain got v=%b d=%h g=%0d exp v=0 d=5 g=3",
               out_valid, out_data, grant); end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 3'd1; in_data = 16'h00C0; in_valid = 4'b0010;
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 4'hC || grant !== 3'd1) begin failures++;
      $display("FAIL bp_load got d=%h g=%0d exp d=c g=1", out_data, grant); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = 3'(i); in_data = 16'h9876 + 16'(i); in_valid = 4'hF;
      #1;
      checks++; if (in_ready !== 4'h0) begin failures++;
        $display("FAIL bp_ready%0d got=%b exp=0000", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 4'hC || grant !== 3'd1) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b d=%h g=%0d exp v=1 d=c g=1",
                 i, out_valid, out_data, grant); end
    end
    out_ready = 1'b1; sel = 3'd0; in_data = 16'h0006; in_valid = 4'b0001;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++;
      $display("FAIL bp_release_ready got=%b exp=0001", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 4'h6 || grant !== 3'd0) begin
      failures++;
      $display("FAIL bp_release got v=%b d=%h g=%0d exp v=1 d=6 g=0",
               out_valid, out_data, grant); end
    in_valid = 4'h0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL bp_drain got v=%b exp=0", out_valid); end
  endtask

  task automatic test_rr_fair();
    logic [2:0] exp_g [8];
    logic [2:0] alt_g [3];
    exp_g = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    alt_g = '{3'd1, 3'd3, 3'd1};
    mode = 1'b1; in_data = 16'h4321; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || grant !== exp_g[i] ||
          out_data !== 4'(exp_g[i] + 3'd1)) begin
        failures++;
        $display("FAIL rr_all%0d got v=%b g=%0d d=%h exp g=%0d",
                 i, out_valid, grant, out_data, exp_g[i]); end
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (grant !== alt_g[i]) begin failures++;
        $display("FAIL rr_alt%0d got g=%0d exp g=%0d", i, grant, alt_g[i]); end
    end
  endtask

  task automatic test_rr_wrap();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1000;
    tick();
    checks++; if (grant !== 3'd3) begin failures++;
      $display("FAIL wrap_set3 got g=%0d exp=3", grant); end
    in_valid = 4'b0100;
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++;
      $display("FAIL wrap_ready got=%b exp=0100", in_ready); end
    tick();
    checks++; if (grant !== 3'd2 || out_data !== 4'h3) begin failures++;
      $display("FAIL wrap_skip got g=%0d d=%h exp g=2 d=3", grant, out_data); end
    in_valid = 4'b0001;
    tick();
    checks++; if (grant !== 3'd0 || out_data !== 4'h1) begin failures++;
      $display("FAIL wrap_zero got g=%0d d=%h exp g=0 d=1", grant, out_data); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
    tick();
    checks++; if (out_valid !== 1'b1 || grant !== 3'd1) begin failures++;
      $display("FAIL mid_pre got v=%b g=%0d exp v=1 g=1", out_valid, grant); end
    #2; rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 4'h0) begin failures++;
      $display("FAIL mid_drop got v=%b rdy=%b exp v=0 rdy=0000",
               out_valid, in_ready); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (in_ready !== 4'b0001) begin failures++;
      $display("FAIL mid_ready got=%b exp=0001", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || grant !== 3'd0) begin failures++;
      $display("FAIL mid_first got v=%b g=%0d exp v=1 g=0", out_valid, grant); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_rr_fair();
    test_rr_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
